step_dir_cnt_mc: RTL and testbench

Multi-channel step/direction position counter for the CNC motion readback path. Each of CH channels synchronises and debounces an external step/dir pair, counts filtered step rising edges up or down, and flags direction-setup violations. All channels are captured by one snapshot strobe, so the position set stays coherent. Counters, snapshots and status are exposed on a 16-bit register bus.

---
 rtl/step_dir_cnt_mc.sv | 220 ++++++++++++++++++++++
 tb/tb_step_dir_cnt_mc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_dir_cnt_mc.sv
// Multi-channel step/direction position counter with debounced inputs,
// coherent snapshot capture and a 16-bit register bus.
module step_dir_cnt_mc #(
  parameter int unsigned CH    = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned FILT  = 2,
  parameter int unsigned SETUP = 2,
  localparam int unsigned A    = $clog2(2 * CH + 1)
) (
  input  logic            clk,
  input  logic            aclr,
  input  logic            sclr_i,
  input  logic [A-1:0]    addr_i,
  input  logic [1:0]      be_i,
  input  logic [15:0]     wrdata_i,
  input  logic            write_i,
  input  logic            read_i,
  output logic [15:0]     rddata_o,
  input  logic            snapshot_i,
  input  logic [CH-1:0]   step_i,
  input  logic [CH-1:0]   dir_i,
  output logic [CH*W-1:0] cnt_o,
  output logic [CH-1:0]   err_o
);

  // Synchronisers plus one extra delay stage for edge/change detection.
  logic [CH-1:0] step_s1_q, step_s1_d, step_s2_q, step_s2_d, step_sd_q, step_sd_d;
  logic [CH-1:0] dir_s1_q, dir_s1_d, dir_s2_q, dir_s2_d, dir_sd_q, dir_sd_d;

  logic [CH-1:0] filt_q, filt_d, filt_dly_q, filt_dly_d;
  logic [CH-1:0] pulse_q, pulse_d;
  logic [3:0]    run_q [CH];
  logic [3:0]    run_d [CH];
  logic [3:0]    stab_q [CH];
  logic [3:0]    stab_d [CH];
  // Dir was not held long enough around the step edge now in the filter.
  logic [CH-1:0] setup_bad_q, setup_bad_d;

  logic [W-1:0]  live_q [CH];
  logic [W-1:0]  live_d [CH];
  logic [W-1:0]  snap_q [CH];
  logic [W-1:0]  snap_d [CH];
  logic [CH-1:0] err_q, err_d;
  logic [15:0]   rddata_q, rddata_d;

  logic [CH-1:0] dir_chg;
  logic [CH-1:0] step_rise;

  assign dir_chg   = dir_s2_q ^ dir_sd_q;
  assign step_rise = step_s2_q & ~step_sd_q;

  // Merge one 16-bit half of a counter under byte enables; bits >= W drop out.
  function automatic logic [W-1:0] merge_half(input logic [W-1:0] cur, input logic hi,
                                               input logic [1:0] be, input logic [15:0] wd);
    logic [31:0] v;
    v = 32'(cur);
    if (!hi) begin
      if (be[0]) v[7:0]  = wd[7:0];
      if (be[1]) v[15:8] = wd[15:8];
    end else begin
      if (be[0]) v[23:16] = wd[7:0];
      if (be[1]) v[31:24] = wd[15:8];
    end
    return v[W-1:0];
  endfunction

  function automatic logic [15:0] hi_half(input logic [W-1:0] cur);
    return 16'(32'(cur) >> 16);
  endfunction

  // Next-state for the filter, counters, status, snapshot and read path.
  always_comb begin
    step_s1_d   = step_i;
    step_s2_d   = step_s1_q;
    step_sd_d   = step_s2_q;
    dir_s1_d    = dir_i;
    dir_s2_d    = dir_s1_q;
    dir_sd_d    = dir_s2_q;
    filt_d      = filt_q;
    filt_dly_d  = filt_q;
    pulse_d     = filt_q & ~filt_dly_q;
    run_d       = run_q;
    stab_d      = stab_q;
    setup_bad_d = setup_bad_q;
    live_d      = live_q;
    snap_d      = snap_q;
    err_d       = err_q;
    rddata_d    = rddata_q;

    if (write_i && be_i[0] && int'(addr_i) == int'(2 * CH)) begin
      err_d = err_q & ~wrdata_i[CH-1:0];
    end

    for (int c = 0; c < CH; c++) begin
      if (step_s2_q[c] != filt_q[c]) begin
        if (run_q[c] >= 4'(FILT - 1)) begin
          filt_d[c] = step_s2_q[c];
          run_d[c]  = '0;
        end else begin
          run_d[c] = run_q[c] + 4'd1;
        end
      end else begin
        run_d[c] = '0;
      end

      if (dir_chg[c]) begin
        stab_d[c] = '0;
      end else if (stab_q[c] < 4'(SETUP)) begin
        stab_d[c] = stab_q[c] + 4'd1;
      end

      // Setup is judged at the synchronised step edge; a dir change after it
      // but before the resulting pulse also counts as a violation.
      if (SETUP != 0) begin
        if (step_rise[c]) begin
          setup_bad_d[c] = (stab_d[c] < 4'(SETUP));
        end else if (dir_chg[c]) begin
          setup_bad_d[c] = 1'b1;
        end
        if (pulse_q[c] && (setup_bad_q[c] || dir_chg[c])) begin
          err_d[c] = 1'b1;
        end
      end

      if (write_i && int'(addr_i) == 2 * c) begin
        live_d[c] = merge_half(live_q[c], 1'b0, be_i, wrdata_i);
      end else if (write_i && int'(addr_i) == 2 * c + 1) begin
        live_d[c] = merge_half(live_q[c], 1'b1, be_i, wrdata_i);
      end
      if (pulse_q[c]) begin
        live_d[c] = dir_s2_q[c] ? live_d[c] - W'(1) : live_d[c] + W'(1);
      end

      // Snapshot takes the pre-update value so all channels line up.
      if (snapshot_i) begin
        snap_d[c] = live_q[c];
      end
    end

    if (read_i) begin
      rddata_d = '0;
      for (int c = 0; c < CH; c++) begin
        if (int'(addr_i) == 2 * c) begin
          rddata_d = snap_q[c][15:0];
        end else if (int'(addr_i) == 2 * c + 1) begin
          rddata_d = hi_half(snap_q[c]);
        end
      end
      if (int'(addr_i) == int'(2 * CH)) begin
        rddata_d[CH-1:0] = err_q;
      end
    end

    if (sclr_i) begin
      step_s1_d   = '0;
      step_s2_d   = '0;
      step_sd_d   = '0;
      dir_s1_d    = '0;
      dir_s2_d    = '0;
      dir_sd_d    = '0;
      filt_d      = '0;
      filt_dly_d  = '0;
      pulse_d     = '0;
      run_d       = '{default: '0};
      stab_d      = '{default: '0};
      setup_bad_d = '0;
      live_d      = '{default: '0};
      snap_d      = '{default: '0};
      err_d       = '0;
      rddata_d    = '0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      step_s1_q   <= '0;
      step_s2_q   <= '0;
      step_sd_q   <= '0;
      dir_s1_q    <= '0;
      dir_s2_q    <= '0;
      dir_sd_q    <= '0;
      filt_q      <= '0;
      filt_dly_q  <= '0;
      pulse_q     <= '0;
      run_q       <= '{default: '0};
      stab_q      <= '{default: '0};
      setup_bad_q <= '0;
      live_q      <= '{default: '0};
      snap_q      <= '{default: '0};
      err_q       <= '0;
      rddata_q    <= '0;
    end else begin
      step_s1_q   <= step_s1_d;
      step_s2_q   <= step_s2_d;
      step_sd_q   <= step_sd_d;
      dir_s1_q    <= dir_s1_d;
      dir_s2_q    <= dir_s2_d;
      dir_sd_q    <= dir_sd_d;
      filt_q      <= filt_d;
      filt_dly_q  <= filt_dly_d;
      pulse_q     <= pulse_d;
      run_q       <= run_d;
      stab_q      <= stab_d;
      setup_bad_q <= setup_bad_d;
      live_q      <= live_d;
      snap_q      <= snap_d;
      err_q       <= err_d;
      rddata_q    <= rddata_d;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_cnt
    assign cnt_o[g*W +: W] = snap_q[g];
  end

  assign err_o    = err_q;
  assign rddata_o = rddata_q;

endmodule

// File: tb/tb_step_dir_cnt_mc.sv
// Directed bench for step_dir_cnt_mc (CH=4, W=32, FILT=2, SETUP=2).
module tb_step_dir_cnt_mc;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned A  = $clog2(2 * CH + 1);

  logic            clk = 1'b0;
  logic            aclr;
  logic            sclr;
  logic [A-1:0]    addr;
  logic [1:0]      be;
  logic [15:0]     wrdata;
  logic            write;
  logic            read;
  logic [15:0]     rddata;
  logic            snapshot;
  logic [CH-1:0]   step;
  logic [CH-1:0]   dir;
  logic [CH*W-1:0] cnt;
  logic [CH-1:0]   err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] rd;

  step_dir_cnt_mc #(.CH(CH), .W(W), .FILT(2), .SETUP(2)) dut (
    .clk        (clk),
    .aclr       (aclr),
    .sclr_i     (sclr),
    .addr_i     (addr),
    .be_i       (be),
    .wrdata_i   (wrdata),
    .write_i    (write),
    .read_i     (read),
    .rddata_o   (rddata),
    .snapshot_i (snapshot),
    .step_i     (step),
    .dir_i      (dir),
    .cnt_o      (cnt),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [1:0] b, input logic [15:0] d);
    addr = A'(a); be = b; wrdata = d; write = 1'b1;
    tick(1);
    write = 1'b0;
  endtask

  task automatic do_read(input int a, output logic [15:0] d);
    addr = A'(a); read = 1'b1;
    tick(1);
    read = 1'b0;
    d = rddata;
  endtask

  task automatic do_snap();
    snapshot = 1'b1;
    tick(1);
    snapshot = 1'b0;
  endtask

  task automatic pulse(input logic [CH-1:0] m, input int hi, input int lo);
    step = step | m;
    tick(hi);
    step = step & ~m;
    tick(lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aclr = 1'b1; sclr = 1'b0; addr = '0; be = '0; wrdata = '0; write = 1'b0;
    read = 1'b0; snapshot = 1'b0; step = '0; dir = '0;
    tick(3);
    check_eq("reset_cnt", cnt, 0);
    check_eq("reset_err", err, 0);
    check_eq("reset_rddata", rddata, 0);
    aclr = 1'b0;
    tick(4);

    // Count up on ch0; snapshot edges 5,6,7 pin the first increment at edge 6.
    step[0] = 1'b1;
    tick(4);
    step[0] = 1'b0;
    snapshot = 1'b1;
    tick(1);
    check_eq("lat_edge5", cnt[31:0], 0);
    tick(1);
    check_eq("lat_edge6_pre", cnt[31:0], 0);
    tick(1);
    check_eq("lat_edge7", cnt[31:0], 1);
    snapshot = 1'b0;
    tick(1);
    for (int i = 0; i < 9; i++) pulse(4'b0001, 4, 4);
    tick(8);
    do_snap();
    do_read(0, rd);
    check_eq("count_up_lo", rd, 16'h000A);
    do_read(1, rd);
    check_eq("count_up_hi", rd, 16'h0000);

    // Wrap-around on ch1, then byte-enable merges.
    do_write(2, 2'b11, 16'h0000);
    do_write(3, 2'b11, 16'h0000);
    dir[1] = 1'b1;
    tick(5);
    pulse(4'b0010, 4, 4);
    tick(6);
    do_snap();
    check_eq("wrap_cnt1", cnt[63:32], 32'hFFFF_FFFF);
    do_read(3, rd);
    check_eq("wrap_rd_hi", rd, 16'hFFFF);
    do_read(9, rd);
    check_eq("undef_addr_rd", rd, 16'h0000);
    check_eq("wrap_no_err", err, 0);
    do_write(2, 2'b01, 16'h1234);
    do_write(3, 2'b10, 16'hAB00);
    do_snap();
    do_read(2, rd);
    check_eq("be_lo", rd, 16'hFF34);
    do_read(3, rd);
    check_eq("be_hi", rd, 16'hABFF);

    // Glitch rejection on ch2.
    pulse(4'b0100, 1, 6);
    tick(4);
    do_snap();
    check_eq("glitch_hi_1cyc", cnt[95:64], 0);
    pulse(4'b0100, 2, 4);
    tick(4);
    do_snap();
    check_eq("pulse_2cyc", cnt[95:64], 1);
    pulse(4'b0100, 6, 1);
    pulse(4'b0100, 6, 6);
    do_snap();
    check_eq("glitch_lo_1cyc", cnt[95:64], 2);

    // Dir toggled with the step edge: violation flagged, count follows new dir.
    dir[2] = 1'b1;
    pulse(4'b0100, 4, 4);
    tick(4);
    do_snap();
    check_eq("setup_cnt2", cnt[95:64], 1);
    check_eq("setup_err", err, 4'b0100);
    do_read(8, rd);
    check_eq("status_rd", rd, 16'h0004);
    do_write(8, 2'b01, 16'h0004);
    check_eq("status_w1c", err, 0);

    // Write colliding with the step pulse on ch3.
    do_write(6, 2'b11, 16'h0064);
    do_write(7, 2'b11, 16'h0000);
    do_snap();
    do_read(6, rd);
    check_eq("ch3_preset", rd, 16'h0064);
    step[3] = 1'b1;
    tick(4);
    step[3] = 1'b0;
    tick(1);
    do_write(6, 2'b11, 16'h0200);
    tick(6);
    do_snap();
    do_read(6, rd);
    check_eq("collision", rd, 16'h0201);

    // Snapshot on the same edge as the pulses captures pre-pulse values.
    dir = '0;
    tick(6);
    step = 4'hF;
    tick(4);
    step = '0;
    tick(1);
    do_snap();
    check_eq("coh_pre_ch0", cnt[31:0], 32'd10);
    check_eq("coh_pre_ch1", cnt[63:32], 32'hABFF_FF34);
    check_eq("coh_pre_ch2", cnt[95:64], 32'd1);
    check_eq("coh_pre_ch3", cnt[127:96], 32'h0000_0201);
    tick(6);
    do_snap();
    check_eq("coh_post_ch0", cnt[31:0], 32'd11);
    check_eq("coh_post_ch1", cnt[63:32], 32'hABFF_FF35);
    check_eq("coh_post_ch2", cnt[95:64], 32'd2);
    check_eq("coh_post_ch3", cnt[127:96], 32'h0000_0202);
    do_read(0, rd);
    check_eq("pre_aclr_rd", rd, 16'h000B);

    // Asynchronous clear with pulses in flight.
    step = 4'hF;
    tick(5);
    aclr = 1'b1;
    step = '0;
    #1;
    check_eq("aclr_cnt", cnt, 0);
    check_eq("aclr_err", err, 0);
    check_eq("aclr_rddata", rddata, 0);
    tick(1);
    aclr = 1'b0;
    tick(10);
    do_snap();
    check_eq("aclr_no_late", cnt, 0);

    // Synchronous clear.
    do_write(0, 2'b11, 16'h0055);
    do_snap();
    check_eq("sclr_pre", cnt[31:0], 32'h55);
    sclr = 1'b1;
    tick(1);
    sclr = 1'b0;
    check_eq("sclr_cnt", cnt, 0);
    do_snap();
    check_eq("sclr_live", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
